serial_arith_sequencer: RTL and testbench
=========================================

// Module: serial_arith_sequencer
// PURPOSE
//  Bit-serial sequencer for the 1-bit ArithmeticSegment slice (B-select mux + full adder).
//  Computes a WIDTH-bit arithmetic op on one slice, LSB first, one bit per clock.
//  Holds the carry between bits and shifts operands and result.
//  Area-reduced alternative to the parallel ALU arithmetic path; single requester, start/done handshake.
// PARAMETERS
//  WIDTH    8   operand/result width in bits; >= 2
// PORTS
//  clk       in   1      rising-edge clock
//  rst_n     in   1      asynchronous reset, active-low
//  start     in   1      request; accepted only in IDLE
//  op        in   2      slice select S: 00 A+B+Cin, 01 A+~B+Cin, 10 A+Cin, 11 A+all-ones+Cin
//  a         in   WIDTH  operand A, sampled on accepted start
//  b         in   WIDTH  operand B, sampled on accepted start (ignored for op 10/11)
//  cin       in   1      initial carry, sampled on accepted start
//  busy      out  1      high in RUN and DONE states
//  done      out  1      one-cycle pulse; result/cout/zero valid from this cycle
//  result    out  WIDTH  final sum; held until the next accepted start
//  cout      out  1      carry out of bit WIDTH-1; held like result
//  zero      out  1      result == 0; held like result
// BEHAVIOUR
//  Clock and reset: one clock domain. rst_n low (async): state=IDLE; busy, done, result, cout, zero, bit counter and carry flop = 0.
//  FSM: IDLE -> RUN on start; RUN -> DONE when counter == WIDTH-1 at the clock edge; DONE -> IDLE unconditionally.
//  Accept: start=1 in IDLE latches a->A_sh, b->B_sh, op->op_r, cin->carry, counter=0.
//   op_r stays stable for the whole operation.
//  RUN, per cycle:
//   - Slice inputs: A_sh[0], B_sh[0], carry, S=op_r.
//   - Slice sum shifts into result_sh MSB; A_sh/B_sh shift right.
//   - Slice carry-out -> carry; counter++.
//  Latency: start accepted at edge 0 -> RUN for WIDTH edges -> done=1 during cycle WIDTH+1.
//  DONE (one cycle): done=1; result, cout and zero update at the DONE-entry edge.
//   cout = final carry; zero = (result == 0). result is the unsigned WIDTH-bit sum.
//   All results wrap mod 2^WIDTH, with the overflow carry reported in cout.
//  Outputs outside DONE: result/cout/zero keep the last completed value (0 after reset).
//   Intermediate shift state is never visible on result.
//  start while busy (RUN or DONE): ignored, no queuing; operands are not resampled.
//  start high continuously: the next operation is accepted in the IDLE cycle after DONE.
//   Back-to-back throughput: one operation per WIDTH+2 cycles.
//  Async reset mid-RUN: the operation is aborted, no done pulse, outputs return to reset values.
//   The first start after reset release is accepted normally.
//  Arithmetic notes:
//   - op 01 with cin=1 gives A-B; cout=1 means no borrow.
//   - op 11 with cin=0 gives A-1; cout=1 unless A==0.
//   - op 10 with cin=1 gives A+1.
//  Undefined inputs on a/b/op/cin while not accepting have no effect.
// TESTING
//  T1: op=00 a=8'h3C b=8'h0F cin=0 -> done in cycle 9 after start; result=8'h4B cout=0 zero=0.
//  T2: op=01 a=8'h10 b=8'h01 cin=1 -> result=8'h0F cout=1. Then a=8'h01 b=8'h02 cin=1 -> result=8'hFF cout=0.
//  T3: op=11 a=8'h00 cin=0 -> result=8'hFF cout=0. Then op=10 a=8'hFF cin=1 -> result=8'h00 cout=1 zero=1.
//  T4: start with a=8'h01 b=8'h01 op=00; pulse start again in RUN with a=8'hAA -> single done, result=8'h02.
//      busy is high for exactly WIDTH+1 cycles.
//  T5: start held high for 3 ops -> done pulses spaced WIDTH+2 cycles apart; each result correct.
//  T6: assert rst_n=0 at bit 4 of an add -> immediately busy=0 result=0, no done pulse.
//      A new add after release completes correctly.

Source files
------------

// File: rtl/serial_arith_sequencer.sv
// Bit-serial arithmetic sequencer: one ArithmeticSegment slice driven LSB first, one bit per clock.
// Latency WIDTH+1 cycles from an accepted start to the done pulse; start is ignored while busy.
module serial_arith_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUBB = 2'b01;
  localparam logic [1:0] OP_PASS = 2'b10;
  localparam logic [1:0] OP_ONES = 2'b11;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [1:0]       op_q, op_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;

  // The 1-bit slice: B-select mux feeding a full adder.
  logic slice_b;
  logic slice_sum;
  logic slice_co;

  always_comb begin
    slice_b = 1'b0;
    case (op_q)
      OP_ADD:  slice_b = b_sh_q[0];
      OP_SUBB: slice_b = ~b_sh_q[0];
      OP_PASS: slice_b = 1'b0;
      OP_ONES: slice_b = 1'b1;
      default: slice_b = 1'b0;
    endcase
  end

  assign slice_sum = a_sh_q[0] ^ slice_b ^ carry_q;
  assign slice_co  = (a_sh_q[0] & slice_b) | (a_sh_q[0] & carry_q) | (slice_b & carry_q);

  logic             last_bit;
  logic [WIDTH-1:0] res_next;

  assign last_bit = (cnt_q == CW'(WIDTH - 1));
  assign res_next = {slice_sum, res_sh_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    op_d     = op_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          op_d     = op;
          carry_d  = cin;
          cnt_d    = '0;
          res_sh_d = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        res_sh_d = res_next;
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        carry_d  = slice_co;
        cnt_d    = cnt_q + 1'b1;
        // Publish only the completed word so partial shifts never reach result.
        if (last_bit) begin
          result_d = res_next;
          cout_d   = slice_co;
          zero_d   = (res_next == '0);
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      op_q     <= OP_ADD;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
    end
  end

  assign busy   = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;
  assign cout   = cout_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_serial_arith_sequencer.sv
// Directed bench for serial_arith_sequencer: expected words are queued at issue and checked on each done pulse.
module tb_serial_arith_sequencer;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         zero;

  serial_arith_sequencer #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .zero   (zero)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         co;
    logic         z;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: compares every done pulse against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_cycle", cyc, e.due);
          chk("result", int'(result), int'(e.res));
          chk("cout", int'(cout), int'(e.co));
          chk("zero", int'(zero), int'(e.z));
        end
      end
      if (busy) busy_cnt++;
      else if (busy_cnt != 0) begin
        chk("busy_len", busy_cnt, W + 1);
        busy_cnt = 0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic push_exp(input logic [W-1:0] r, input logic c, input int due);
    exp_t e;
    e.res = r;
    e.co  = c;
    e.z   = (r == '0);
    e.due = due;
    sb.push_back(e);
  endtask

  // Issue one op at the next idle negedge; accept edge is cyc+1, done visible W edges later.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic ci, input logic [W-1:0] er, input logic ec);
    @(negedge clk);
    wait_idle();
    op = o; a = av; b = bv; cin = ci; start = 1'b1;
    push_exp(er, ec, cyc + 1 + W);
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 'x; b = 'x; op = 'x; cin = 1'bx;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  logic [W-1:0] t5_a [3] = '{8'h80, 8'h7F, 8'hA5};
  logic [W-1:0] t5_b [3] = '{8'h80, 8'h00, 8'h5A};
  logic [1:0]   t5_o [3] = '{2'b00, 2'b10, 2'b01};
  logic         t5_c [3] = '{1'b0, 1'b1, 1'b0};
  logic [W-1:0] t5_r [3] = '{8'h00, 8'h80, 8'h4A};
  logic         t5_k [3] = '{1'b1, 1'b0, 1'b1};

  initial begin
    int acc;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_cout", cout, 0);
    chk("rst_zero", zero, 0);
    rst_n = 1'b1;

    // T1..T3 plus extra corner vectors
    run_op(2'b00, 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0);
    run_op(2'b01, 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1);
    run_op(2'b01, 8'h01, 8'h02, 1'b1, 8'hFF, 1'b0);
    run_op(2'b11, 8'h00, 8'h5A, 1'b0, 8'hFF, 1'b0);
    run_op(2'b10, 8'hFF, 8'h33, 1'b1, 8'h00, 1'b1);
    run_op(2'b00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    run_op(2'b11, 8'h05, 8'h00, 1'b0, 8'h04, 1'b1);
    drain();

    // T4: extra start pulse during RUN must be ignored
    run_op(2'b00, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);
    repeat (3) @(negedge clk);
    a = 8'hAA; b = 8'h55; op = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    chk("t4_result_held", result, 8'h02);

    // T5: start held high across three back-to-back ops
    @(negedge clk);
    wait_idle();
    acc = cyc + 1;
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      op = t5_o[k]; a = t5_a[k]; b = t5_b[k]; cin = t5_c[k];
      sb.push_back('{res: t5_r[k], co: t5_k[k], z: (t5_r[k] == '0), due: acc + W});
      while (cyc < acc) @(posedge clk);
      #1;
      if (k == 2) start = 1'b0;
      acc = acc + W + 2;
    end
    drain();
    chk("t5_result_held", result, 8'h4A);

    // T6: asynchronous reset in the middle of an add
    run_op(2'b00, 8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    void'(sb.pop_back());
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_result", result, 0);
    chk("t6_cout", cout, 0);
    chk("t6_done", done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 3) @(negedge clk);
    chk("t6_no_done_result", result, 0);
    run_op(2'b00, 8'h64, 8'h64, 1'b0, 8'hC8, 1'b0);
    drain();

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
